// File: rtl/ad_emu_tx.sv
// Dual-channel ADC emulator, transmit side.
// Per-channel waveform generators feed a converter-like output pipeline.
module ad_emu_tx #(
    parameter int unsigned DW       = 10,
    parameter int unsigned PIPE_LAT = 3,
    parameter int unsigned DIV_W    = 8
) (
    input  logic             clk_20M,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic [DW-1:0]    step,
    input  logic [1:0]       mode1,
    input  logic [1:0]       mode2,
    input  logic [DW+1:0]    offset1,
    input  logic [DW+1:0]    offset2,
    input  logic             ad1oe,
    input  logic             ad2oe,
    output logic [DW-1:0]    ad_data1,
    output logic [DW-1:0]    ad_data2,
    output logic             OTR1,
    output logic             OTR2,
    output logic             smp_stb
);

    localparam logic [DW-1:0] MAX = {DW{1'b1}};
    localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        M_RAMP  = 2'd0,
        M_TRI   = 2'd1,
        M_CONST = 2'd2,
        M_SQR   = 2'd3
    } mode_e;

    typedef struct packed {
        logic [DW-1:0] acc;
        logic          down;
        mode_e         mode;
    } ch_st_t;

    typedef struct packed {
        ch_st_t        st;
        logic [DW-1:0] base;
    } ch_nxt_t;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] s1;
        logic          o1;
        logic [DW-1:0] s2;
        logic          o2;
    } stage_t;

    function automatic ch_nxt_t advance(input ch_st_t cur,
                                        input logic [1:0] m,
                                        input logic [DW-1:0] stp);
        ch_nxt_t     r;
        logic [DW:0] up;
        r      = '{st: cur, base: cur.acc};
        up     = {1'b0, cur.acc} + {1'b0, stp};
        // A mode change restarts the channel from zero on this very tick.
        if (mode_e'(m) != cur.mode) begin
            r.st.mode = mode_e'(m);
            r.st.acc  = '0;
            r.st.down = 1'b0;
            r.base    = '0;
        end else begin
            unique case (cur.mode)
                M_RAMP: begin
                    r.st.acc = up[DW-1:0];
                    r.base   = up[DW-1:0];
                end
                M_TRI: begin
                    if (!cur.down) begin
                        if (up >= {1'b0, MAX}) begin
                            r.st.acc  = MAX;
                            r.st.down = 1'b1;
                        end else begin
                            r.st.acc = up[DW-1:0];
                        end
                    end else if (cur.acc <= stp) begin
                        r.st.acc  = '0;
                        r.st.down = 1'b0;
                    end else begin
                        r.st.acc = cur.acc - stp;
                    end
                    r.base = r.st.acc;
                end
                M_CONST: r.base = MID;
                M_SQR: begin
                    r.st.acc = up[DW-1:0];
                    r.base   = up[DW-1] ? MAX : '0;
                end
            endcase
        end
        return r;
    endfunction

    // Returns {otr, sample}; one spare bit keeps base+offset from wrapping.
    function automatic logic [DW:0] clamp(input logic [DW-1:0] base,
                                          input logic [DW+1:0] off);
        logic signed [DW+2:0] sum;
        sum = $signed({3'b000, base}) + $signed({off[DW+1], off});
        if (sum < 0) begin
            return {1'b1, {DW{1'b0}}};
        end else if (sum > $signed({3'b000, MAX})) begin
            return {1'b1, MAX};
        end
        return {1'b0, sum[DW-1:0]};
    endfunction

    logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
    logic                   tick;
    ch_st_t                 ch1_q, ch1_d, ch2_q, ch2_d;
    ch_nxt_t                nx1, nx2;
    logic [DW:0]            r1, r2;
    stage_t                 stg0;
    stage_t [PIPE_LAT-1:0]  pipe_q, pipe_d;
    stage_t [PIPE_LAT:0]    chain;
    stage_t                 last;
    logic [DW-1:0]          data1_q, data2_q;
    logic                   otr1_q, otr2_q, stb_q;

    always_comb begin
        tick      = en && (div_cnt_q == div);
        div_cnt_d = (!en || tick) ? '0 : div_cnt_q + 1'b1;
        nx1       = advance(ch1_q, mode1, step);
        nx2       = advance(ch2_q, mode2, step);
        ch1_d     = tick ? nx1.st : ch1_q;
        ch2_d     = tick ? nx2.st : ch2_q;
        r1        = clamp(nx1.base, offset1);
        r2        = clamp(nx2.base, offset2);
        stg0.v    = tick;
        stg0.s1   = r1[DW-1:0];
        stg0.o1   = r1[DW];
        stg0.s2   = r2[DW-1:0];
        stg0.o2   = r2[DW];
        chain     = {pipe_q, stg0};
        pipe_d    = chain[PIPE_LAT-1:0];
        last      = chain[PIPE_LAT];
    end

    always_ff @(posedge clk_20M or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            ch1_q     <= '0;
            ch2_q     <= '0;
            pipe_q    <= '0;
            data1_q   <= '0;
            data2_q   <= '0;
            otr1_q    <= 1'b0;
            otr2_q    <= 1'b0;
            stb_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            ch1_q     <= ch1_d;
            ch2_q     <= ch2_d;
            pipe_q    <= pipe_d;
            stb_q     <= last.v;
            if (last.v) begin
                data1_q <= last.s1;
                otr1_q  <= last.o1;
                data2_q <= last.s2;
                otr2_q  <= last.o2;
            end
        end
    end

    assign ad_data1 = ad1oe ? '0 : data1_q;
    assign OTR1     = ad1oe ? 1'b0 : otr1_q;
    assign ad_data2 = ad2oe ? '0 : data2_q;
    assign OTR2     = ad2oe ? 1'b0 : otr2_q;
    assign smp_stb  = stb_q;

endmodule

// File: tb/tb_ad_emu_tx.sv
// Scoreboard bench for ad_emu_tx: per-tick reference model feeds a queue,
// a negedge monitor pops on every strobe and checks data, OTR and latency.
module tb_ad_emu_tx;

    localparam int PL = 3;

    logic        clk_20M;
    logic        rst;
    logic        en;
    logic [7:0]  div;
    logic [9:0]  step;
    logic [1:0]  mode1, mode2;
    logic [11:0] offset1, offset2;
    logic        ad1oe, ad2oe;
    logic [9:0]  ad_data1, ad_data2;
    logic        OTR1, OTR2, smp_stb;

    int off1, off2;
    assign offset1 = off1[11:0];
    assign offset2 = off2[11:0];

    ad_emu_tx #(.DW(10), .PIPE_LAT(PL), .DIV_W(8)) dut (
        .clk_20M (clk_20M),
        .rst     (rst),
        .en      (en),
        .div     (div),
        .step    (step),
        .mode1   (mode1),
        .mode2   (mode2),
        .offset1 (offset1),
        .offset2 (offset2),
        .ad1oe   (ad1oe),
        .ad2oe   (ad2oe),
        .ad_data1(ad_data1),
        .ad_data2(ad_data2),
        .OTR1    (OTR1),
        .OTR2    (OTR2),
        .smp_stb (smp_stb)
    );

    initial begin
        clk_20M = 1'b0;
        forever #5 clk_20M = ~clk_20M;
    end

    int cyc = 0;
    always @(posedge clk_20M) cyc <= cyc + 1;

    typedef struct {
        int due;
        int s1;
        int o1;
        int s2;
        int o2;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   l1 = 0, lo1 = 0, l2 = 0, lo2 = 0;

    // Reference model state: accumulator, direction, latched mode, divider.
    int macc[2];
    int mup[2];
    int mmode[2];
    int mcnt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            macc[c]  = 0;
            mup[c]   = 1;
            mmode[c] = 0;
        end
        mcnt = 0;
    endtask

    function automatic void model_tick(input int c, input int md,
                                       input int off, input int st,
                                       output int s, output int o);
        int base;
        if (md != mmode[c]) begin
            mmode[c] = md;
            macc[c]  = 0;
            mup[c]   = 1;
            base     = 0;
        end else begin
            case (md)
                0: begin
                    macc[c] = (macc[c] + st) % 1024;
                    base    = macc[c];
                end
                1: begin
                    if (mup[c] != 0) begin
                        if (macc[c] + st >= 1023) begin
                            macc[c] = 1023;
                            mup[c]  = 0;
                        end else macc[c] = macc[c] + st;
                    end else begin
                        if (macc[c] <= st) begin
                            macc[c] = 0;
                            mup[c]  = 1;
                        end else macc[c] = macc[c] - st;
                    end
                    base = macc[c];
                end
                2: base = 512;
                default: begin
                    macc[c] = (macc[c] + st) % 1024;
                    base    = (macc[c] >= 512) ? 1023 : 0;
                end
            endcase
        end
        s = base + off;
        o = 0;
        if (s < 0) begin
            s = 0;
            o = 1;
        end else if (s > 1023) begin
            s = 1023;
            o = 1;
        end
    endfunction

    task automatic model_cycle();
        exp_t e;
        bit   tk;
        tk   = en && (mcnt == int'(div));
        mcnt = (!en || tk) ? 0 : (mcnt + 1) % 256;
        if (tk) begin
            model_tick(0, int'(mode1), off1, int'(step), e.s1, e.o1);
            model_tick(1, int'(mode2), off2, int'(step), e.s2, e.o2);
            e.due = cyc + 1 + PL;
            sb.push_back(e);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            model_cycle();
            @(posedge clk_20M);
            #1;
        end
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_data1"}, ad_data1, 0);
        chk({tag, "_data2"}, ad_data2, 0);
        chk({tag, "_otr1"}, OTR1, 0);
        chk({tag, "_otr2"}, OTR2, 0);
        chk({tag, "_stb"}, smp_stb, 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check_reset_outs(tag);
        sb.delete();
        model_reset();
        l1  = 0;
        lo1 = 0;
        l2  = 0;
        lo2 = 0;
        @(posedge clk_20M);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk_20M) begin
        if (!rst) begin
            if (smp_stb) begin
                if (sb.size() == 0) begin
                    chk("stb_unexpected", smp_stb, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("latency", cyc, mon_e.due);
                    l1  = mon_e.s1;
                    lo1 = mon_e.o1;
                    l2  = mon_e.s2;
                    lo2 = mon_e.o2;
                end
            end
            chk("ad_data1", ad_data1, ad1oe ? 0 : l1);
            chk("OTR1", OTR1, ad1oe ? 0 : lo1);
            chk("ad_data2", ad_data2, ad2oe ? 0 : l2);
            chk("OTR2", OTR2, ad2oe ? 0 : lo2);
        end
    end

    initial begin
        rst   = 1'b0;
        en    = 1'b0;
        div   = 8'd0;
        step  = 10'd1;
        mode1 = 2'd0;
        mode2 = 2'd0;
        off1  = 0;
        off2  = 0;
        ad1oe = 1'b0;
        ad2oe = 1'b0;
        model_reset();
        #1;
        do_reset("por");

        // Ramp step 1 through the 1023 -> 0 wrap, then reset mid-run.
        en = 1'b1;
        run(1100);
        do_reset("midrst");
        run(8);

        // Triangle on ch1, ramp with step 300 on ch2.
        mode1 = 2'd1;
        step  = 10'd300;
        run(12);

        // Constant mode offsets around both rails.
        mode1 = 2'd2;
        off1  = 600;
        run(4);
        off1  = -600;
        run(4);
        off1  = -512;
        run(4);
        off1  = 511;
        run(4);
        off1  = 0;

        // Divided tick rate, ch2 switches ramp -> square mid-run.
        mode1 = 2'd0;
        step  = 10'd7;
        en    = 1'b0;
        run(2);
        div   = 8'd4;
        en    = 1'b1;
        run(30);
        mode2 = 2'd3;
        run(30);

        // Output-enable window on ch1 while the ramp keeps running.
        div   = 8'd0;
        mode2 = 2'd0;
        run(5);
        ad1oe = 1'b1;
        run(10);
        ad1oe = 1'b0;
        run(10);

        // Pause and resume the generator.
        en = 1'b0;
        run(5);
        en = 1'b1;
        run(5);
        en = 1'b0;
        run(10);
        en = 1'b1;
        run(5);

        // Randomized segments.
        for (int s = 0; s < 40; s++) begin
            mode1 = 2'($urandom_range(0, 3));
            mode2 = 2'($urandom_range(0, 3));
            step  = 10'($urandom_range(0, 1023));
            div   = 8'($urandom_range(0, 3));
            off1  = int'($urandom_range(0, 2047)) - 1024;
            off2  = int'($urandom_range(0, 2047)) - 1024;
            en    = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 15; i++) begin
                ad1oe = ($urandom_range(0, 3) == 0);
                ad2oe = ($urandom_range(0, 3) == 0);
                run(1);
            end
        end

        // Drain everything in flight within a bounded window.
        en    = 1'b0;
        ad1oe = 1'b0;
        ad2oe = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) run(1);
        run(2);
        chk("drain_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
